// File: rtl/tqvp_reg_arbiter.sv
// Two-master round-robin arbiter for the TinyQV peripheral register port.
// Define REG_ARB_FIXED_PRIORITY_EN to make port A always win simultaneous requests.
module tqvp_reg_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic              lock_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic              lock_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              data_write,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t            state, state_d;
    logic              owner, owner_d;
    logic              lock_q, lock_d;
    logic              grant;
    logic              grant_port;
    logic              owner_req_c;
    logic              owner_lock_c;
    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] data_in_d;
    logic              data_write_d;
    logic              ack_a_d, ack_b_d;
    logic [DATA_W-1:0] rdata_a_d, rdata_b_d;
    logic              busy_d;
`ifndef REG_ARB_FIXED_PRIORITY_EN
    logic              last, last_d;
`endif

    assign owner_req_c  = (owner == PORT_A) ? req_a  : req_b;
    assign owner_lock_c = (owner == PORT_A) ? lock_a : lock_b;

    // Next-state and next-output computation; every output is the registered copy of its _d.
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        lock_d       = lock_q;
        address_d    = address;
        data_in_d    = data_in;
        data_write_d = 1'b0;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        rdata_a_d    = rdata_a;
        rdata_b_d    = rdata_b;
        grant        = 1'b0;
        grant_port   = owner;
`ifndef REG_ARB_FIXED_PRIORITY_EN
        last_d       = last;
`endif

        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    grant = 1'b1;
`ifdef REG_ARB_FIXED_PRIORITY_EN
                    grant_port = req_a ? PORT_A : PORT_B;
`else
                    if (req_a && req_b) grant_port = ~last;
                    else                grant_port = req_a ? PORT_A : PORT_B;
`endif
                end
            end
            DRIVE: state_d = CAPTURE;
            CAPTURE: begin
                if (owner == PORT_A) begin
                    rdata_a_d = data_out;
                    ack_a_d   = 1'b1;
                end else begin
                    rdata_b_d = data_out;
                    ack_b_d   = 1'b1;
                end
                state_d = lock_q ? HOLD : IDLE;
            end
            HOLD: begin
                // Only the owner can be granted while it holds the lock.
                if (owner_req_c) begin
                    grant      = 1'b1;
                    grant_port = owner;
                end else if (!owner_lock_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            state_d = DRIVE;
            owner_d = grant_port;
`ifndef REG_ARB_FIXED_PRIORITY_EN
            last_d  = grant_port;
`endif
            if (grant_port == PORT_A) begin
                address_d    = addr_a;
                data_in_d    = wdata_a;
                data_write_d = we_a;
                lock_d       = lock_a;
            end else begin
                address_d    = addr_b;
                data_in_d    = wdata_b;
                data_write_d = we_b;
                lock_d       = lock_b;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= PORT_A;
            lock_q     <= 1'b0;
            address    <= '0;
            data_in    <= '0;
            data_write <= 1'b0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            rdata_a    <= '0;
            rdata_b    <= '0;
            busy       <= 1'b0;
`ifndef REG_ARB_FIXED_PRIORITY_EN
            last       <= PORT_B;
`endif
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            lock_q     <= lock_d;
            address    <= address_d;
            data_in    <= data_in_d;
            data_write <= data_write_d;
            ack_a      <= ack_a_d;
            ack_b      <= ack_b_d;
            rdata_a    <= rdata_a_d;
            rdata_b    <= rdata_b_d;
            busy       <= busy_d;
`ifndef REG_ARB_FIXED_PRIORITY_EN
            last       <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Directed self-checking bench for tqvp_reg_arbiter with a small register-file peripheral model.
module tb_tqvp_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, we_a, lock_a, req_b, we_b, lock_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       ack_a, ack_b;
    logic [7:0] rdata_a, rdata_b;
    logic [3:0] address;
    logic [7:0] data_in;
    logic       data_write;
    logic [7:0] data_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];

    tqvp_reg_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .address(address), .data_in(data_in), .data_write(data_write),
        .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Peripheral: reset contents are index ^ 0xC4 (addr 7 -> 0xC3), writes land on the strobe edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i) ^ 8'hC4;
        end else if (data_write) begin
            mem[address] <= data_in;
        end
    end
    assign data_out = mem[address];

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 0; we_a = 0; lock_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; lock_b = 0; addr_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        checks++; if ({address, data_in, rdata_a, rdata_b} !== 28'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {address, data_in, rdata_a, rdata_b}); end
        checks++; if ({data_write, ack_a, ack_b, busy} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {data_write, ack_a, ack_b, busy}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_a();
        req_a = 1; we_a = 1; addr_a = 4'h3; wdata_a = 8'h5A;
        @(negedge clk);
        checks++; if ({data_write, address, data_in, busy, ack_a} !== {1'b1, 4'h3, 8'h5A, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wr_drive got we=%b a=%h d=%h busy=%b ack=%b exp 1 3 5a 1 0",
                data_write, address, data_in, busy, ack_a); end
        @(negedge clk);
        checks++; if ({data_write, ack_a, address} !== {1'b0, 1'b0, 4'h3}) begin
            errors++; $display("FAIL wr_capture got we=%b ack=%b a=%h exp 0 0 3", data_write, ack_a, address); end
        @(negedge clk);
        checks++; if ({ack_a, ack_b, rdata_a} !== {1'b1, 1'b0, 8'h5A}) begin
            errors++; $display("FAIL wr_ack got ack_a=%b ack_b=%b rdata_a=%h exp 1 0 5a", ack_a, ack_b, rdata_a); end
        req_a = 0; we_a = 0;
        @(negedge clk);
        checks++; if ({ack_a, busy, data_write} !== 3'b000) begin
            errors++; $display("FAIL wr_after got ack=%b busy=%b we=%b exp 000", ack_a, busy, data_write); end
    endtask

    task automatic test_read_b();
        logic saw_we = 1'b0;
        req_b = 1; we_b = 0; addr_b = 4'h7;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            saw_we |= data_write;
        end
        @(negedge clk);
        saw_we |= data_write;
        checks++; if ({ack_b, ack_a, rdata_b, rdata_a} !== {1'b1, 1'b0, 8'hC3, 8'h5A}) begin
            errors++; $display("FAIL rd_b got ack_b=%b ack_a=%b rdata_b=%h rdata_a=%h exp 1 0 c3 5a",
                ack_b, ack_a, rdata_b, rdata_a); end
        checks++; if (saw_we !== 1'b0) begin
            errors++; $display("FAIL rd_b_nowrite got %b exp 0", saw_we); end
        req_b = 0;
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        logic order [8];
        logic exp_order [8];
        int   n = 0, cnt_a = 0, cnt_b = 0;
        logic both = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef REG_ARB_FIXED_PRIORITY_EN
            exp_order[i] = (i >= 4);
`else
            exp_order[i] = i[0];
`endif
            order[i] = 1'bx;
        end
        req_a = 1; we_a = 0; addr_a = 4'h1;
        req_b = 1; we_b = 0; addr_b = 4'h2;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            @(negedge clk);
            both |= ack_a & ack_b;
            if (ack_a) begin
                checks++; if (rdata_a !== 8'hC5) begin
                    errors++; $display("FAIL arb_rdata_a got %h exp c5", rdata_a); end
                order[n] = 1'b0; n++; cnt_a++;
                if (cnt_a == 4) req_a = 0;
            end else if (ack_b) begin
                checks++; if (rdata_b !== 8'hC6) begin
                    errors++; $display("FAIL arb_rdata_b got %h exp c6", rdata_b); end
                order[n] = 1'b1; n++; cnt_b++;
                if (cnt_b == 4) req_b = 0;
            end
        end
        checks++; if (n !== 8) begin
            errors++; $display("FAIL arb_count got %0d exp 8", n); end
        checks++; if (both !== 1'b0) begin
            errors++; $display("FAIL arb_dual_ack got %b exp 0", both); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (order[i] !== exp_order[i]) begin
                errors++; $display("FAIL arb_order[%0d] got %b exp %b (0=A)", i, order[i], exp_order[i]); end
        end
        req_a = 0; req_b = 0;
        @(negedge clk);
    endtask

    task automatic test_lock();
        int   cyc = 0;
        logic seen_b = 1'b0;
        req_a = 1; lock_a = 1; we_a = 0; addr_a = 4'h2;
        req_b = 1; we_b = 0; addr_b = 4'h5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_a || ack_b) break;
        end
        checks++; if ({ack_a, ack_b, rdata_a} !== {1'b1, 1'b0, 8'hC6}) begin
            errors++; $display("FAIL lock_rd got ack_a=%b ack_b=%b rdata_a=%h exp 1 0 c6", ack_a, ack_b, rdata_a); end
        we_a = 1; wdata_a = 8'h77;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            seen_b |= ack_b;
            if (ack_a) break;
        end
        checks++; if ({ack_a, rdata_a, seen_b} !== {1'b1, 8'h77, 1'b0}) begin
            errors++; $display("FAIL lock_wr got ack_a=%b rdata_a=%h seen_b=%b exp 1 77 0", ack_a, rdata_a, seen_b); end
        checks++; if (cyc !== 3) begin
            errors++; $display("FAIL lock_latency got %0d exp 3", cyc); end
        req_a = 0; lock_a = 0; we_a = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_b) break;
        end
        checks++; if ({ack_b, rdata_b} !== {1'b1, 8'hC1}) begin
            errors++; $display("FAIL lock_b_served got ack_b=%b rdata_b=%h exp 1 c1", ack_b, rdata_b); end
        req_b = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        logic bad = 1'b0;
        req_a = 1; we_a = 1; addr_a = 4'h4; wdata_a = 8'h99;
        @(negedge clk);
        checks++; if (data_write !== 1'b1) begin
            errors++; $display("FAIL rst_mid_drive got %b exp 1", data_write); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({data_write, ack_a, busy, address, rdata_a} !== 15'h0) begin
            errors++; $display("FAIL rst_mid_async got we=%b ack=%b busy=%b a=%h rdata_a=%h exp all 0",
                data_write, ack_a, busy, address, rdata_a); end
        req_a = 0; we_a = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bad |= ack_a | ack_b | busy | data_write;
        end
        checks++; if (bad !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet got %b exp 0", bad); end
        req_a = 1; we_a = 1; addr_a = 4'h4; wdata_a = 8'h99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_a) break;
        end
        checks++; if ({ack_a, rdata_a} !== {1'b1, 8'h99}) begin
            errors++; $display("FAIL rst_mid_reissue got ack=%b rdata_a=%h exp 1 99", ack_a, rdata_a); end
        req_a = 0; we_a = 0;
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        req_b = 1; we_b = 0; addr_b = 4'h7;
        @(negedge clk);
        req_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_b) break;
        end
        checks++; if ({ack_b, rdata_b} !== {1'b1, 8'hC3}) begin
            errors++; $display("FAIL early_drop got ack_b=%b rdata_b=%h exp 1 c3", ack_b, rdata_b); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL early_drop_idle got busy=%b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_read_b();
        test_arbitration();
        test_lock();
        test_reset_mid_access();
        test_early_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/tqvp_reg_arbiter.md
# tqvp_reg_arbiter

Two-master arbiter for the 4-bit-address / 8-bit-data peripheral register port of a TinyQV peripheral. Sits between the peripheral and two requesters (e.g. the SPI register bridge on port A and an on-chip sequencer or debug master on port B). It serialises their accesses and drives the peripheral's `address`, `data_in` and `data_write` signals. It returns `data_out` to the winning requester with a one-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, 4, register address width
- `DATA_W`, 8, register data width

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock, all state on rising edge
- `rst_n` input 1: asynchronous active-low reset
- `req_a` / `req_b` input 1: access request, held until ack
- `we_a` / `we_b` input 1: 1 = write, 0 = read
- `lock_a` / `lock_b` input 1: keep grant after this access (atomic RMW sequences)
- `addr_a` / `addr_b` input ADDR_W: register address
- `wdata_a` / `wdata_b` input DATA_W: write data
- `ack_a` / `ack_b` output 1: one-cycle completion pulse
- `rdata_a` / `rdata_b` output DATA_W: read data, valid while ack is high, then held
- `address` output ADDR_W: to peripheral
- `data_in` output DATA_W: write data to peripheral
- `data_write` output 1: one-cycle write strobe to peripheral
- `data_out` input DATA_W: read data from peripheral, combinational from `address`
- `busy` output 1: high in any state other than IDLE

## Operation
- States: IDLE, DRIVE, CAPTURE, HOLD.
- **IDLE**
  - Arbitrate among the requests that are high.
  - Record the winner in `owner` and register its addr, wdata and we.
  - Go to DRIVE.
- **DRIVE**
  - `address` = latched address.
  - `data_in` = latched data.
  - `data_write` = latched we, for exactly this cycle.
  - Go to CAPTURE.
- **CAPTURE**
  - `address` is still held.
  - Sample `data_out` into the owner's rdata, whether the access was a read or a write.
  - Pulse the owner's ack.
  - If the owner's lock was high when its request was latched, go to HOLD; otherwise go to IDLE.
- **HOLD**
  - Only the owner may be granted.
  - Owner's req high: latch it and go to DRIVE.
  - Owner's lock low and req low: go to IDLE.
  - The other requester waits.
- Round-robin: `last` records the most recently served port. On simultaneous requests, the port that is not `last` wins. `last` resets to B, so A wins first.
- Requesters hold req, we, lock, addr and wdata stable until ack. req sampled high in the cycle after ack is a new request.
- `ack_a` and `ack_b` are never high together. `data_write` is never high outside DRIVE.
- The non-owner's rdata is untouched.

## Timing
- Reset values:
  - state IDLE; `owner` A; `last` B.
  - `address`, `data_in`, `rdata_a`, `rdata_b` = 0.
  - `data_write`, `ack_a`, `ack_b`, `busy` = 0.
- Latency: req first high at edge N (in IDLE) gives `data_write` during cycle N+1 and ack during cycle N+2. The next IDLE grant is at edge N+3, so each access takes 3 cycles.
- Locked back-to-back access: HOLD to DRIVE takes 1 cycle, so 3 cycles per access.
- All outputs are registered. No combinational path from req to peripheral outputs.
- Reset asserted mid-access: the state returns to IDLE immediately, and `data_write` and the acks drop asynchronously. The pending request is not completed and must be re-issued.
- Owner deasserts req before ack (protocol violation): the access completes anyway and ack still pulses.

## Configuration
- `REG_ARB_FIXED_PRIORITY_EN`
  - Defined: port A always wins simultaneous requests, and `last` is not used (tied/unused).
  - Undefined (default): round-robin as above.
- Lock/HOLD behaviour is identical in both builds.

## Test plan
- Reset, then A writes 0x5A to addr 0x3 -> `data_write` high for exactly 1 cycle with `address` 0x3 and `data_in` 0x5A; `ack_a` pulses 2 cycles after req; `ack_b` stays 0.
- B reads addr 0x7 while peripheral returns 0xC3 -> `rdata_b` = 0xC3 during `ack_b`; `data_write` never asserted; `rdata_a` unchanged.
- A and B request together, repeatedly, 4 times each -> grants alternate A,B,A,B,…. With `REG_ARB_FIXED_PRIORITY_EN` defined, all 4 A accesses complete before any B access.
- A holds lock: read 0x2, then write 0x2 while B requests continuously -> both A accesses complete before `ack_b`. B is served after A drops lock and req.
- Assert `rst_n` low during DRIVE of an A write -> `data_write` drops at once; after release, no ack and `busy` = 0. A re-issues and the access completes normally.
